// File: rtl/seq_alu.sv
// +----------------------------------------------------------------------------+
// | seq_alu : multi-cycle integer ALU with valid/ready in/out handshakes.       |
// |   imul/idiv(/irem) iterate one bit per cycle; macro SEQ_ALU_IREM_EN adds   |
// |   opcode F = unsigned remainder.                                           |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/1ps

module seq_alu #(
  parameter int WIDTH = 16,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       alu_op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] c,
  output logic             ofl,
  output logic             err
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [3:0] c_OP_LEFT = 4'h0;
  localparam logic [3:0] c_OP_IADD = 4'h1;
  localparam logic [3:0] c_OP_ISUB = 4'h2;
  localparam logic [3:0] c_OP_IMUL = 4'h3;
  localparam logic [3:0] c_OP_IDIV = 4'h4;
  localparam logic [3:0] c_OP_BAND = 4'h9;
  localparam logic [3:0] c_OP_BIOR = 4'hA;
  localparam logic [3:0] c_OP_BXOR = 4'hB;
  localparam logic [3:0] c_OP_ISHL = 4'hC;
`ifdef SEQ_ALU_IREM_EN
  localparam logic [3:0] c_OP_IREM = 4'hF;
`endif

  localparam logic [WIDTH-1:0] c_WIDTH_V = WIDTH'(WIDTH);
  localparam logic [CNT_W-1:0] c_CNT_LOAD = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(1);

  logic [1:0]       r_state;
  logic [1:0]       w_next_state;
  logic [3:0]       r_op;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_c;
  logic             r_ofl;
  logic             r_err;
  logic [CNT_W-1:0] r_cnt;

  logic             w_accept;
  logic             w_is_multi;
  logic [WIDTH-1:0] w_c;
  logic             w_ofl;
  logic             w_err;
  logic [WIDTH-1:0] w_add;
  logic [WIDTH-1:0] w_sub;
  logic             w_b_neg;
  logic [WIDTH-1:0] w_b_mag;
  logic [WIDTH-1:0] w_shl;

  logic [WIDTH:0]   w_sum;
  logic [WIDTH-1:0] w_mul_hi;
  logic [WIDTH-1:0] w_mul_lo;
  logic [WIDTH:0]   w_shift;
  logic             w_ge;
  logic [WIDTH-1:0] w_div_hi;
  logic [WIDTH-1:0] w_div_lo;
  logic [WIDTH-1:0] w_step_hi;
  logic [WIDTH-1:0] w_step_lo;
  logic [WIDTH-1:0] w_fin_c;
  logic             w_fin_ofl;

  assign w_accept = in_valid && in_ready;
  assign w_add    = a + b;
  assign w_sub    = a - b;
  // Negating the most-negative shift count leaves it unchanged, still >= WIDTH.
  assign w_b_neg  = b[WIDTH-1];
  assign w_b_mag  = w_b_neg ? (~b + 1'b1) : b;
  assign w_shl    = (w_b_mag >= c_WIDTH_V) ? '0 :
                    (w_b_neg ? (a >> w_b_mag) : (a << w_b_mag));

  always_comb begin
    w_c        = '0;
    w_ofl      = 1'b0;
    w_err      = 1'b0;
    w_is_multi = 1'b0;
    case (alu_op)
      c_OP_LEFT: w_c = a;
      c_OP_IADD: begin
        w_c   = w_add;
        w_ofl = (a[WIDTH-1] == b[WIDTH-1]) && (w_add[WIDTH-1] != a[WIDTH-1]);
      end
      c_OP_ISUB: begin
        w_c   = w_sub;
        w_ofl = (a[WIDTH-1] != b[WIDTH-1]) && (w_sub[WIDTH-1] != a[WIDTH-1]);
      end
      c_OP_IMUL: w_is_multi = 1'b1;
      c_OP_IDIV: begin
        if (b == '0) begin
          w_err = 1'b1;
          w_c   = '1;
        end else begin
          w_is_multi = 1'b1;
        end
      end
      c_OP_BAND: w_c = a & b;
      c_OP_BIOR: w_c = a | b;
      c_OP_BXOR: w_c = a ^ b;
      c_OP_ISHL: w_c = w_shl;
`ifdef SEQ_ALU_IREM_EN
      c_OP_IREM: begin
        if (b == '0) begin
          w_err = 1'b1;
          w_c   = a;
        end else begin
          w_is_multi = 1'b1;
        end
      end
`endif
      default: w_err = 1'b1;
    endcase
  end

  // r_hi/r_lo hold {partial product, multiplier} or {remainder, dividend/quotient}.
  assign w_sum     = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);
  assign w_mul_hi  = w_sum[WIDTH:1];
  assign w_mul_lo  = {w_sum[0], r_lo[WIDTH-1:1]};
  assign w_shift   = {r_hi, r_lo[WIDTH-1]};
  assign w_ge      = w_shift >= {1'b0, r_b};
  assign w_div_hi  = w_ge ? (w_shift[WIDTH-1:0] - r_b) : w_shift[WIDTH-1:0];
  assign w_div_lo  = {r_lo[WIDTH-2:0], w_ge};
  assign w_step_hi = (r_op == c_OP_IMUL) ? w_mul_hi : w_div_hi;
  assign w_step_lo = (r_op == c_OP_IMUL) ? w_mul_lo : w_div_lo;

  always_comb begin
    w_fin_c   = w_div_lo;
    w_fin_ofl = 1'b0;
    if (r_op == c_OP_IMUL) begin
      w_fin_c   = w_mul_lo;
      w_fin_ofl = |w_mul_hi;
    end
`ifdef SEQ_ALU_IREM_EN
    else if (r_op == c_OP_IREM) begin
      w_fin_c = w_div_hi;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_next_state = w_is_multi ? S_BUSY : S_DONE;
      S_BUSY: if (r_cnt == c_CNT_LAST) w_next_state = S_DONE;
      S_DONE: if (out_ready) w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (r_state == S_IDLE);
    out_valid = (r_state == S_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op  <= '0;
      r_hi  <= '0;
      r_lo  <= '0;
      r_b   <= '0;
      r_c   <= '0;
      r_ofl <= 1'b0;
      r_err <= 1'b0;
      r_cnt <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_op <= alu_op;
            if (w_is_multi) begin
              r_hi  <= '0;
              r_lo  <= a;
              r_b   <= b;
              r_cnt <= c_CNT_LOAD;
            end else begin
              r_c   <= w_c;
              r_ofl <= w_ofl;
              r_err <= w_err;
            end
          end
        end
        S_BUSY: begin
          r_hi  <= w_step_hi;
          r_lo  <= w_step_lo;
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == c_CNT_LAST) begin
            r_c   <= w_fin_c;
            r_ofl <= w_fin_ofl;
            r_err <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign c   = r_c;
  assign ofl = r_ofl;
  assign err = r_err;

endmodule

`default_nettype wire

// File: tb/tb_seq_alu.sv
// +----------------------------------------------------------------------------+
// | tb_seq_alu : self-checking bench for seq_alu (WIDTH=16).                    |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/1ps

module tb_seq_alu;

  localparam int W = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [3:0]    alu_op;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  c;
  logic          ofl;
  logic          err;

  int n_checks = 0;
  int n_errors = 0;

  seq_alu #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .alu_op    (alu_op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .c         (c),
    .ofl       (ofl),
    .err       (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [3:0] op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] c;
    logic       ofl;
    logic       err;
    int         lat;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference model: plain integer arithmetic on the opcode definitions.
  function automatic void model(input logic [3:0] op, input logic [15:0] av, input logic [15:0] bv,
                                output logic [15:0] ec, output logic eofl, output logic eerr,
                                output int elat);
    int          sa, sb, r;
    logic [31:0] p;
    ec = '0; eofl = 1'b0; eerr = 1'b0; elat = 0;
    sa = $signed(av);
    sb = $signed(bv);
    case (op)
      4'h0: ec = av;
      4'h1: begin r = sa + sb; ec = av + bv; eofl = (r > 32767) || (r < -32768); end
      4'h2: begin r = sa - sb; ec = av - bv; eofl = (r > 32767) || (r < -32768); end
      4'h3: begin
        p = {16'h0, av} * {16'h0, bv};
        ec = p[15:0]; eofl = (p[31:16] != 0); elat = W;
      end
      4'h4: if (bv == 0) begin ec = 16'hFFFF; eerr = 1'b1; end
            else begin ec = av / bv; elat = W; end
      4'h9: ec = av & bv;
      4'hA: ec = av | bv;
      4'hB: ec = av ^ bv;
      4'hC: begin
        if (sb >= 0 && sb < W) ec = av << sb;
        else if (sb < 0 && sb > -W) ec = av >> (-sb);
        else ec = '0;
      end
`ifdef SEQ_ALU_IREM_EN
      4'hF: if (bv == 0) begin ec = av; eerr = 1'b1; end
            else begin ec = av % bv; elat = W; end
`endif
      default: eerr = 1'b1;
    endcase
  endfunction

  // Issue one op, wait for its result, hold it for 'hold' cycles, then hand off.
  task automatic run_op(input logic [3:0] op, input logic [15:0] av, input logic [15:0] bv,
                        input int hold, output logic [15:0] rc, output logic rofl,
                        output logic rerr, output int lat);
    int guard;
    @(negedge clk);
    guard = 0;
    while (!in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    chk("in_ready_before_issue", in_ready, 1);
    in_valid = 1'b1; alu_op = op; a = av; b = bv;
    @(posedge clk); #1;
    in_valid = 1'b0; a = 16'($urandom); b = 16'($urandom); alu_op = 4'($urandom);
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("out_valid_timeout", out_valid, 1);
    rc = c; rofl = ofl; rerr = err;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk("hold_c_stable", c, rc);
      chk("hold_in_ready_low", in_ready, 0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("handoff_out_valid", out_valid, 0);
    chk("handoff_in_ready", in_ready, 1);
  endtask

  initial begin
    vec_t        vecs[$];
    logic [15:0] rc, ec, ra, rb;
    logic        rofl, rerr, eofl, eerr;
    int          lat, elat, hold;
    logic [3:0]  rop;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    alu_op = '0; a = '0; b = '0;

    vecs.push_back('{"iadd_1_1",      4'h1, 16'h0001, 16'h0001, 16'h0002, 1'b0, 1'b0, 0});
    vecs.push_back('{"iadd_ovf",      4'h1, 16'h7FFF, 16'h0001, 16'h8000, 1'b1, 1'b0, 0});
    vecs.push_back('{"imul_f_ff",     4'h3, 16'h000F, 16'h00FF, 16'h0EF1, 1'b0, 1'b0, W});
    vecs.push_back('{"imul_ovf",      4'h3, 16'h0100, 16'h0100, 16'h0000, 1'b1, 1'b0, W});
    vecs.push_back('{"idiv_20_7",     4'h4, 16'h0014, 16'h0007, 16'h0002, 1'b0, 1'b0, W});
    vecs.push_back('{"idiv_by0",      4'h4, 16'h0001, 16'h0000, 16'hFFFF, 1'b0, 1'b1, 0});
    vecs.push_back('{"ishl_msb_out",  4'hC, 16'h8000, 16'h0001, 16'h0000, 1'b0, 1'b0, 0});
    vecs.push_back('{"ishl_neg1",     4'hC, 16'h8000, 16'hFFFF, 16'h4000, 1'b0, 1'b0, 0});
    vecs.push_back('{"ishl_16",       4'hC, 16'h0001, 16'h0010, 16'h0000, 1'b0, 1'b0, 0});
    vecs.push_back('{"ishl_mostneg",  4'hC, 16'h0001, 16'h8000, 16'h0000, 1'b0, 1'b0, 0});
    vecs.push_back('{"isub_ovf",      4'h2, 16'h8000, 16'h0001, 16'h7FFF, 1'b1, 1'b0, 0});
    vecs.push_back('{"left",          4'h0, 16'h1234, 16'hABCD, 16'h1234, 1'b0, 1'b0, 0});
    vecs.push_back('{"float_op5",     4'h5, 16'h1234, 16'h0001, 16'h0000, 1'b0, 1'b1, 0});
    vecs.push_back('{"band",          4'h9, 16'h5555, 16'h0F0F, 16'h0505, 1'b0, 1'b0, 0});
    vecs.push_back('{"bior",          4'hA, 16'h5555, 16'h0F0F, 16'h5F5F, 1'b0, 1'b0, 0});
    vecs.push_back('{"bxor",          4'hB, 16'h5555, 16'h0F0F, 16'h5A5A, 1'b0, 1'b0, 0});
    vecs.push_back('{"itof",          4'hD, 16'h0003, 16'h0000, 16'h0000, 1'b0, 1'b1, 0});
`ifdef SEQ_ALU_IREM_EN
    vecs.push_back('{"irem_20_7",     4'hF, 16'h0014, 16'h0007, 16'h0006, 1'b0, 1'b0, W});
    vecs.push_back('{"irem_by0",      4'hF, 16'h0014, 16'h0000, 16'h0014, 1'b0, 1'b1, 0});
`else
    vecs.push_back('{"op_f_unsup",    4'hF, 16'h0014, 16'h0007, 16'h0000, 1'b0, 1'b1, 0});
`endif

    #2;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_c", c, 0);
    chk("rst_ofl", ofl, 0);
    chk("rst_err", err, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, 0, rc, rofl, rerr, lat);
      chk({vecs[i].name, "_c"},   rc,   vecs[i].c);
      chk({vecs[i].name, "_ofl"}, rofl, vecs[i].ofl);
      chk({vecs[i].name, "_err"}, rerr, vecs[i].err);
      chk({vecs[i].name, "_lat"}, lat,  vecs[i].lat);
    end

    // Back-pressure: result held, second request ignored while DONE.
    @(negedge clk);
    in_valid = 1'b1; alu_op = 4'h9; a = 16'h5555; b = 16'h0F0F;
    @(posedge clk); #1;
    alu_op = 4'h1; a = 16'h1234; b = 16'h0001;
    chk("bp_out_valid", out_valid, 1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_c", c, 16'h0505);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_out_valid_held", out_valid, 1);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    chk("bp_release_in_ready", in_ready, 1);
    chk("bp_release_out_valid", out_valid, 0);
    @(posedge clk); #1;
    chk("bp_no_second_accept", out_valid, 0);
    chk("bp_still_idle", in_ready, 1);

    // Reset during an imul aborts it at once.
    @(negedge clk);
    in_valid = 1'b1; alu_op = 4'h3; a = 16'h00FF; b = 16'h00FF;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (7) @(posedge clk);
    #2;
    chk("midop_busy", in_ready, 0);
    rst = 1'b1;
    #1;
    chk("abort_in_ready", in_ready, 1);
    chk("abort_out_valid", out_valid, 0);
    chk("abort_c", c, 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("abort_no_result", out_valid, 0);
    run_op(4'h1, 16'h0003, 16'h0004, 0, rc, rofl, rerr, lat);
    chk("post_abort_iadd_c", rc, 16'h0007);
    chk("post_abort_iadd_lat", lat, 0);

    // Randomized ops against the reference model, with random back-pressure.
    for (int n = 0; n < 150; n++) begin
      rop = 4'($urandom_range(0, 15));
      ra  = 16'($urandom);
      case ($urandom_range(0, 3))
        0:       rb = 16'h0000;
        1:       rb = 16'($urandom_range(0, 40) - 20);
        default: rb = 16'($urandom);
      endcase
      hold = $urandom_range(0, 3);
      model(rop, ra, rb, ec, eofl, eerr, elat);
      run_op(rop, ra, rb, hold, rc, rofl, rerr, lat);
      chk("rand_c",   rc,   ec);
      chk("rand_ofl", rofl, eofl);
      chk("rand_err", rerr, eerr);
      chk("rand_lat", lat,  elat);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/seq_alu.md
Name: seq_alu

Overview:
- Parametrised, multi-cycle successor to the 16-bit combinational ALU, for the datapath integer unit.
- Width is set by parameter.
- Multiply and divide are iterative: shift-add and restoring division, one bit per cycle.
- Operands arrive on a valid/ready handshake, and results leave on a second one with back-pressure; the block holds one operation at a time.

Parameters:
WIDTH, 16, operand/result width in bits; legal range 4..64.
CNT_W, $clog2(WIDTH)+1, iteration counter width; derived, do not override.

Ports:
clk  input  1  single clock, rising edge
rst  input  1  reset, asynchronous, active-high
in_valid  input  1  operation offered
in_ready  output  1  block can accept an operation
alu_op  input  4  opcode, sampled on accept
a  input  WIDTH  left operand, sampled on accept
b  input  WIDTH  right operand, sampled on accept
out_valid  output  1  result available
out_ready  input  1  consumer takes result
c  output  WIDTH  result
ofl  output  1  overflow flag for the result
err  output  1  error flag for the result

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-high.
- Reset values:
  - State is IDLE.
  - in_ready=1, out_valid=0, c=0, ofl=0, err=0.
  - Internal accumulators and counter are 0.
- Reset asserted mid-operation aborts the operation immediately. No result is produced for it.
- States:
  - IDLE: in_ready=1. Accept occurs when in_valid&&in_ready at a rising edge.
  - BUSY: imul/idiv iterating; in_ready=0, out_valid=0.
  - DONE: out_valid=1; c/ofl/err are stable until handoff. Handoff occurs when out_valid&&out_ready at an edge, then the state returns to IDLE.
  - in_ready is low in DONE, so a new operation is never accepted on the handoff edge. Minimum issue interval is 2 cycles.
- Latency from accept edge N:
  - Single-cycle ops go IDLE->DONE at edge N, so out_valid is high in cycle N+1.
  - imul/idiv go IDLE->BUSY at N and BUSY->DONE at edge N+WIDTH. The counter loads WIDTH and decrements once per BUSY edge.
- Opcodes (operands unsigned unless stated; c is the low WIDTH bits):
  - 0 left: c=a.
  - 1 iadd: c=a+b; ofl=signed overflow.
  - 2 isub: c=a-b; ofl=signed overflow.
  - 3 imul: unsigned product; ofl=1 if the upper WIDTH bits of the 2*WIDTH product are nonzero.
  - 4 idiv: c=a/b, unsigned quotient. When b==0 the op is single-cycle: err=1, c=all ones.
  - 5..8 (float ops): unsupported. Single-cycle; err=1, c=0.
  - 9 band, A bior, B bxor: bitwise.
  - C ishl: b is read as signed.
    - b>=0: c=a<<b.
    - b<0: c=a>>-b, logical shift.
    - |b|>=WIDTH: c=0.
    - b = most-negative value: c=0.
  - D itof, E utof: unsupported; err=1, c=0.
  - F: see Optional Feature.
- ofl and err are 0 for every op and case not listed above.
- in_valid while in_ready=0 is ignored; the bench must hold the request.
- Operands are captured at the accept edge. Changes on a/b/alu_op after accept have no effect.
- out_ready while out_valid=0 has no effect.

Optional Feature:
- Macro: SEQ_ALU_IREM_EN.
- Defined: opcode F is irem. c = a%b unsigned, taken from the restoring divider's remainder with the same WIDTH-cycle latency as idiv. When b==0: err=1, c=a, single-cycle.
- Undefined: opcode F is ftoi-unsupported, giving err=1, c=0, single-cycle. No remainder path is built.

Test Plan:
- Reset, then iadd a=0x1 b=0x1 -> out_valid one cycle after accept, c=0x0002. Then a=0x7FFF b=0x1 -> c=0x8000, ofl=1.
- imul a=0xF b=0xFF with out_ready=1 -> out_valid exactly 16 edges after accept, c=0x0EF1, ofl=0. Then a=0x100 b=0x100 -> c=0, ofl=1.
- idiv a=0x14 b=0x7 -> c=0x0002 after 16 cycles. Then a=0x1 b=0x0 -> err=1, c=0xFFFF, single-cycle.
- ishl a=0x8000 b=0x1 -> c=0x0000. a=0x8000 b=0xFFFF (-1) -> c=0x4000. a=0x1 b=0x10 -> c=0.
- Back-pressure: hold out_ready=0 for 5 cycles after band a=0x5555 b=0x0F0F. Required: c=0x0505 stable, in_ready=0, and a second in_valid is ignored. Release -> IDLE next edge.
- Assert rst mid-imul at cycle 8 -> out_valid=0, in_ready=1 immediately. The next iadd completes correctly.
- With SEQ_ALU_IREM_EN: irem a=0x14 b=0x7 -> c=0x0006 after 16 cycles. Without it: op F -> err=1.
